matrix_prefetch_ctrl: RTL and testbench

Parametrised next-generation matrix read/write controller.
- Converts software-side we/re strobes into RAM address, write enable and read enable.
- Prefetches up to RB_DEPTH entries ahead into the datapath read buffer, tolerating a configurable RAM read latency.
- Optionally reads the matrix in transposed (column-major) order.
- Sits between the top-level register interface and the matrix datapath/BRAM.

---
 rtl/matrix_prefetch_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_matrix_prefetch_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_prefetch_ctrl.sv
// Matrix RAM port controller: turns software we/re strobes into RAM write/read enables and
// prefetches into the datapath read buffer. Column-major reads are built with MATRIX_CTRL_TRANSPOSE_EN.
module matrix_prefetch_ctrl #(
  parameter int ADDR_MSB         = 11,
  parameter int MAT_IDX_SIZE_MSB = 3,
  parameter int RB_DEPTH         = 2,
  parameter int RAM_LAT          = 1
) (
  input  logic                      CLK,
  input  logic                      RST_L,
  input  logic                      clr,
  input  logic                      we,
  input  logic                      re,
  input  logic                      transpose,
  input  logic [MAT_IDX_SIZE_MSB:0] col_idx_size,
  input  logic [MAT_IDX_SIZE_MSB:0] row_idx_size,
  output logic                      wen_to_ram,
  output logic                      ren_to_ram,
  output logic [ADDR_MSB:0]         a,
  output logic                      shift_to_dp,
  output logic [2:0]                out_sel_to_dp,
  output logic                      rd_valid,
  output logic                      rd_err
);

  localparam int AW = ADDR_MSB + 1;
  localparam int CW = ADDR_MSB + 2;
  localparam int SW = MAT_IDX_SIZE_MSB + 1;

  logic [CW-1:0]      rows_s;
  logic [CW-1:0]      cols_s;
  logic [CW-1:0]      n_s;
  logic [CW-1:0]      n_m1_s;
  logic [AW-1:0]      wr_a_r;
  logic [AW-1:0]      wr_a_nxt_s;
  logic [CW-1:0]      wr_cnt_r;
  logic [CW-1:0]      wr_cnt_nxt_s;
  logic [AW-1:0]      f_r;
  logic [AW-1:0]      f_nxt_s;
  logic [AW-1:0]      fetch_addr_s;
  logic [2:0]         rb_cnt_r;
  logic [2:0]         rb_cnt_nxt_s;
  logic [RAM_LAT-1:0] vld_r;
  logic [RAM_LAT-1:0] vld_nxt_s;
  logic [3:0]         inflight_s;
  logic               rd_err_r;
  logic               rd_err_nxt_s;
  logic               pop_s;
  logic               credit_s;
  logic               fetch_ok_s;
  logic               ren_s;

  assign rows_s = CW'(row_idx_size) + CW'(1'b1);
  assign cols_s = CW'(col_idx_size) + CW'(1'b1);
  assign n_s    = rows_s * cols_s;
  assign n_m1_s = n_s - CW'(1'b1);

  // Count reads still travelling through the RAM latency pipe.
  always_comb begin
    inflight_s = 4'd0;
    for (int i = 0; i < RAM_LAT; i++) begin
      inflight_s = inflight_s + {3'd0, vld_r[i]};
    end
  end

  assign pop_s = re & ~clr & (rb_cnt_r != 3'd0);

  // An entry popped this cycle frees its slot, which is what lets a held re stream one per cycle.
  assign credit_s = ({1'b0, inflight_s} + {2'b00, rb_cnt_r}) < (5'(RB_DEPTH) + {4'd0, pop_s});

`ifdef MATRIX_CTRL_TRANSPOSE_EN
  logic          tr_r;
  logic          init_r;
  logic [SW-1:0] t_row_r;
  logic [SW-1:0] t_col_r;
  logic [AW-1:0] t_addr_r;

  // Read-order mode is taken on the first cycle out of reset and on every clr.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      tr_r   <= 1'b0;
      init_r <= 1'b0;
    end else if (clr || !init_r) begin
      tr_r   <= transpose;
      init_r <= 1'b1;
    end
  end

  // Column-major walker: row advances fastest, address tracked as row*C+col without a multiplier.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      t_row_r  <= {SW{1'b0}};
      t_col_r  <= {SW{1'b0}};
      t_addr_r <= {AW{1'b0}};
    end else if (clr) begin
      t_row_r  <= {SW{1'b0}};
      t_col_r  <= {SW{1'b0}};
      t_addr_r <= {AW{1'b0}};
    end else if (ren_s) begin
      if (t_row_r == row_idx_size) begin
        t_row_r <= {SW{1'b0}};
        if (t_col_r == col_idx_size) begin
          t_col_r  <= {SW{1'b0}};
          t_addr_r <= {AW{1'b0}};
        end else begin
          t_col_r  <= t_col_r + SW'(1'b1);
          t_addr_r <= AW'(t_col_r) + AW'(1'b1);
        end
      end else begin
        t_row_r  <= t_row_r + SW'(1'b1);
        t_addr_r <= t_addr_r + cols_s[AW-1:0];
      end
    end
  end

  assign fetch_ok_s   = tr_r ? (wr_cnt_r == n_s) : (CW'(f_r) < wr_cnt_r);
  assign fetch_addr_s = tr_r ? t_addr_r : f_r;
`else
  logic unused_transpose_s;
  assign unused_transpose_s = transpose;
  assign fetch_ok_s         = CW'(f_r) < wr_cnt_r;
  assign fetch_addr_s       = f_r;
`endif

  assign ren_s = ~we & ~clr & fetch_ok_s & credit_s;

  // Next values for the write pointer, write count and fetch index.
  always_comb begin
    wr_a_nxt_s   = wr_a_r;
    wr_cnt_nxt_s = wr_cnt_r;
    f_nxt_s      = f_r;
    if (we) begin
      if (CW'(wr_a_r) == n_m1_s) begin
        wr_a_nxt_s = {AW{1'b0}};
      end else begin
        wr_a_nxt_s = wr_a_r + AW'(1'b1);
      end
      if (wr_cnt_r != n_s) begin
        wr_cnt_nxt_s = wr_cnt_r + CW'(1'b1);
      end else begin
        wr_cnt_nxt_s = wr_cnt_r;
      end
    end else begin
      wr_a_nxt_s   = wr_a_r;
      wr_cnt_nxt_s = wr_cnt_r;
    end
    if (ren_s) begin
      if (CW'(f_r) == n_m1_s) begin
        f_nxt_s = {AW{1'b0}};
      end else begin
        f_nxt_s = f_r + AW'(1'b1);
      end
    end else begin
      f_nxt_s = f_r;
    end
  end

  // Next values for the latency pipe, buffer fill count and sticky error.
  always_comb begin
    vld_nxt_s    = {RAM_LAT{1'b0}};
    rb_cnt_nxt_s = rb_cnt_r;
    rd_err_nxt_s = rd_err_r;
    vld_nxt_s[0] = ren_s;
    for (int i = 1; i < RAM_LAT; i++) begin
      vld_nxt_s[i] = vld_r[i-1];
    end
    case ({shift_to_dp, pop_s})
      2'b10:   rb_cnt_nxt_s = rb_cnt_r + 3'd1;
      2'b01:   rb_cnt_nxt_s = rb_cnt_r - 3'd1;
      default: rb_cnt_nxt_s = rb_cnt_r;
    endcase
    if (re && (rb_cnt_r == 3'd0)) begin
      rd_err_nxt_s = 1'b1;
    end else begin
      rd_err_nxt_s = rd_err_r;
    end
  end

  // Controller state; clr flushes everything including reads already issued.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      wr_a_r   <= {AW{1'b0}};
      wr_cnt_r <= {CW{1'b0}};
      f_r      <= {AW{1'b0}};
      vld_r    <= {RAM_LAT{1'b0}};
      rb_cnt_r <= 3'd0;
      rd_err_r <= 1'b0;
    end else if (clr) begin
      wr_a_r   <= {AW{1'b0}};
      wr_cnt_r <= {CW{1'b0}};
      f_r      <= {AW{1'b0}};
      vld_r    <= {RAM_LAT{1'b0}};
      rb_cnt_r <= 3'd0;
      rd_err_r <= 1'b0;
    end else begin
      wr_a_r   <= wr_a_nxt_s;
      wr_cnt_r <= wr_cnt_nxt_s;
      f_r      <= f_nxt_s;
      vld_r    <= vld_nxt_s;
      rb_cnt_r <= rb_cnt_nxt_s;
      rd_err_r <= rd_err_nxt_s;
    end
  end

  assign wen_to_ram    = we;
  assign ren_to_ram    = ren_s;
  assign a             = we ? wr_a_r : fetch_addr_s;
  assign shift_to_dp   = vld_r[RAM_LAT-1];
  assign out_sel_to_dp = rb_cnt_r;
  assign rd_valid      = (rb_cnt_r != 3'd0);
  assign rd_err        = rd_err_r;

endmodule

// File: tb/tb_matrix_prefetch_ctrl.sv
// Bench for matrix_prefetch_ctrl: two instances (RB_DEPTH=2/RAM_LAT=1 and RB_DEPTH=3/RAM_LAT=3)
// share stimulus and are compared every cycle against a queue-based behavioural model.
module tb_matrix_prefetch_ctrl;

  logic       clk       = 1'b0;
  logic       rst_l     = 1'b1;
  logic       clr       = 1'b0;
  logic       we        = 1'b0;
  logic       re        = 1'b0;
  logic       transpose = 1'b0;
  logic [3:0] row_sz    = 4'd1;
  logic [3:0] col_sz    = 4'd1;

  logic        wen_o [2];
  logic        ren_o [2];
  logic [11:0] a_o   [2];
  logic        sh_o  [2];
  logic [2:0]  sel_o [2];
  logic        vld_o [2];
  logic        err_o [2];

  always #5 clk = ~clk;

  matrix_prefetch_ctrl #(.ADDR_MSB(11), .MAT_IDX_SIZE_MSB(3), .RB_DEPTH(2), .RAM_LAT(1)) u_dut0 (
    .CLK(clk), .RST_L(rst_l), .clr(clr), .we(we), .re(re), .transpose(transpose),
    .col_idx_size(col_sz), .row_idx_size(row_sz),
    .wen_to_ram(wen_o[0]), .ren_to_ram(ren_o[0]), .a(a_o[0]), .shift_to_dp(sh_o[0]),
    .out_sel_to_dp(sel_o[0]), .rd_valid(vld_o[0]), .rd_err(err_o[0]));

  matrix_prefetch_ctrl #(.ADDR_MSB(11), .MAT_IDX_SIZE_MSB(3), .RB_DEPTH(3), .RAM_LAT(3)) u_dut1 (
    .CLK(clk), .RST_L(rst_l), .clr(clr), .we(we), .re(re), .transpose(transpose),
    .col_idx_size(col_sz), .row_idx_size(row_sz),
    .wen_to_ram(wen_o[1]), .ren_to_ram(ren_o[1]), .a(a_o[1]), .shift_to_dp(sh_o[1]),
    .out_sel_to_dp(sel_o[1]), .rd_valid(vld_o[1]), .rd_err(err_o[1]));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int m_wr_a   [2];
  int m_wr_cnt [2];
  int m_f      [2];
  int m_rb     [2];
  bit m_err    [2];
  bit m_tr     [2];
  bit m_init   [2];
  int q0 [$];
  int q1 [$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int q_front(input int k);
    if (q_size(k) == 0) return -1;
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic q_push(input int k, input int v);
    if (k == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic q_pop(input int k);
    if (k == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic model_clear(input int k);
    m_wr_a[k] = 0; m_wr_cnt[k] = 0; m_f[k] = 0; m_rb[k] = 0; m_err[k] = 1'b0;
    if (k == 0) q0.delete();
    else q1.delete();
  endtask

  // Expected outputs for instance k this cycle; optionally advance the model by one clock.
  task automatic model_cycle(input int k, input bit adv);
    int    r, c, n, fa, ea;
    bit    tr_eff, ok, pop, sh, ren;
    string p;
    r = int'(row_sz) + 1;
    c = int'(col_sz) + 1;
    n = r * c;
    tr_eff = 1'b0;
`ifdef MATRIX_CTRL_TRANSPOSE_EN
    tr_eff = m_tr[k];
`endif
    ok  = tr_eff ? (m_wr_cnt[k] == n) : (m_f[k] < m_wr_cnt[k]);
    pop = re && !clr && (m_rb[k] > 0);
    sh  = (q_size(k) > 0) && (q_front(k) == cyc);
    ren = !we && !clr && ok && (q_size(k) + m_rb[k] - int'(pop) < dep(k));
    fa  = tr_eff ? ((m_f[k] % r) * c + m_f[k] / r) : m_f[k];
    ea  = we ? m_wr_a[k] : fa;
    p   = (k == 0) ? "lat1" : "lat3";
    check_eq({p, ".wen"},     int'(wen_o[k]), int'(we));
    check_eq({p, ".ren"},     int'(ren_o[k]), int'(ren));
    check_eq({p, ".a"},       int'(a_o[k]),   ea);
    check_eq({p, ".shift"},   int'(sh_o[k]),  int'(sh));
    check_eq({p, ".out_sel"}, int'(sel_o[k]), m_rb[k]);
    check_eq({p, ".rd_valid"}, int'(vld_o[k]), int'(m_rb[k] > 0));
    check_eq({p, ".rd_err"},  int'(err_o[k]), int'(m_err[k]));
    if (adv) begin
      if (clr) begin
        model_clear(k);
        m_tr[k]   = transpose;
        m_init[k] = 1'b1;
      end else begin
        if (!m_init[k]) begin
          m_tr[k]   = transpose;
          m_init[k] = 1'b1;
        end
        if (re && m_rb[k] == 0) m_err[k] = 1'b1;
        if (we) begin
          m_wr_a[k] = (m_wr_a[k] + 1) % n;
          if (m_wr_cnt[k] < n) m_wr_cnt[k]++;
        end
        if (ren) begin
          q_push(k, cyc + lat(k));
          m_f[k] = (m_f[k] + 1) % n;
        end
        if (sh) q_pop(k);
        m_rb[k] = m_rb[k] + int'(sh) - int'(pop);
      end
    end
  endtask

  task automatic step(input bit w, input bit r, input bit c);
    @(negedge clk);
    we = w; re = r; clr = c;
    #1;
    model_cycle(0, 1'b1);
    model_cycle(1, 1'b1);
    cyc++;
  endtask

  task automatic run(input bit w, input bit r, input int n);
    for (int i = 0; i < n; i++) step(w, r, 1'b0);
  endtask

  // Two-cycle clr so geometry is only changed while the controller is being flushed.
  task automatic flush(input int rs, input int cs, input bit t);
    transpose = t;
    step(1'b0, 1'b0, 1'b1);
    row_sz = 4'(rs);
    col_sz = 4'(cs);
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst_l = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      m_tr[k]   = 1'b0;
      m_init[k] = 1'b0;
      check_eq("reset.ren", int'(ren_o[k]), 0);
      check_eq("reset.out_sel", int'(sel_o[k]), 0);
      model_cycle(k, 1'b0);
    end
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    #1;
    model_cycle(0, 1'b1);
    model_cycle(1, 1'b1);
    cyc++;
  endtask

  initial begin
    row_sz = 4'd1; col_sz = 4'd1; transpose = 1'b0;
    do_reset();

    // Row-major prefetch then sustained reading with wrap (R=C=2).
    run(1'b1, 1'b0, 4);
    run(1'b0, 1'b0, 4);
    run(1'b0, 1'b1, 6);
    run(1'b0, 1'b0, 3);

    // Longer latency: N=8 written, prefetch fills, then drain.
    flush(1, 3, 1'b0);
    run(1'b1, 1'b0, 8);
    run(1'b0, 1'b0, 8);
    run(1'b0, 1'b1, 10);

    // Transposed read order (R=2, C=3).
    flush(1, 2, 1'b1);
    run(1'b1, 1'b0, 6);
    run(1'b0, 1'b0, 3);
    run(1'b0, 1'b1, 12);
    transpose = 1'b0;

    // Partial write, then interleaved we/re.
    flush(1, 1, 1'b0);
    run(1'b1, 1'b0, 1);
    run(1'b0, 1'b0, 3);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    run(1'b0, 1'b0, 4);

    // Empty-read error, then clr with reads in flight.
    flush(1, 3, 1'b0);
    run(1'b0, 1'b1, 2);
    run(1'b0, 1'b0, 1);
    run(1'b1, 1'b0, 8);
    run(1'b0, 1'b0, 2);
    flush(1, 3, 1'b0);
    run(1'b0, 1'b0, 6);

    // Asynchronous reset in the middle of traffic.
    run(1'b1, 1'b0, 5);
    run(1'b0, 1'b0, 1);
    do_reset();
    run(1'b0, 1'b0, 3);

    // Randomized traffic with occasional flush and geometry change.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        flush(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 55), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
